// File: rtl/scan_pkg.sv
// Shared definitions for the bit-scan controller.
//   SCAN_BITS   - frame width (one bit per mux input)
//   SCAN_IDX_W  - width of the mux select index
//   SCAN_CNT_W  - width of the settle down-counter (covers SETTLE up to 15)
//   scan_state_e - controller FSM states
package scan_pkg;

  localparam int unsigned SCAN_BITS  = 8;
  localparam int unsigned SCAN_IDX_W = 3;
  localparam int unsigned SCAN_CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } scan_state_e;

endpackage

// File: rtl/scan_settle_cnt.sv
// Loadable settle down-counter.
// Ports:
//   clk_i      - clock, rising edge
//   reset_i    - asynchronous active-high reset
//   load_i     - load load_val_i (takes priority over dec_i)
//   load_val_i - value to load
//   dec_i      - decrement by one, saturating at zero
//   zero_o     - counter currently holds zero
module scan_settle_cnt
  import scan_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [SCAN_CNT_W-1:0] load_val_i,
  input  logic                  dec_i,
  output logic                  zero_o
);

  logic [SCAN_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - SCAN_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bit_scan_ctrl.sv
// Scans an external 8:1 tristate mux one input at a time and assembles the eight
// samples into a frame handed off with a valid/ready handshake.
// Parameter:
//   SETTLE   - settle cycles per bit after the select lines change (1..15)
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-high reset
//   start    - request one frame scan (accepted only when idle)
//   mux_y    - true output of the mux
//   mux_w    - complement output of the mux
//   ready    - consumer accepts data_out
//   sel_a/b/c - mux select, index = {sel_a, sel_b, sel_c}
//   g_n      - mux enable, active low
//   data_out - assembled frame, bit i sampled at index i
//   valid    - data_out holds a complete frame
//   busy     - controller not idle
//   err      - complement-mismatch flag for the current frame
// Build option:
//   SCAN_WCHECK_EN - when defined, err goes sticky for the frame whenever
//                    mux_w equals mux_y at a sample; otherwise err is 0.
module bit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mux_y,
  input  logic                 mux_w,
  input  logic                 ready,
  output logic                 sel_a,
  output logic                 sel_b,
  output logic                 sel_c,
  output logic                 g_n,
  output logic [SCAN_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 busy,
  output logic                 err
);

  localparam logic [SCAN_CNT_W-1:0] SettleLoad = SCAN_CNT_W'(SETTLE - 1);
  localparam logic [SCAN_IDX_W-1:0] LastIdx    = SCAN_IDX_W'(SCAN_BITS - 1);

  scan_state_e           state_q, state_d;
  logic [SCAN_IDX_W-1:0] idx_q, idx_d;
  logic [SCAN_BITS-1:0]  data_q, data_d;
  logic                  err_q, err_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic w_mismatch;

`ifdef SCAN_WCHECK_EN
  assign w_mismatch = (mux_w == mux_y);
`else
  logic unused_mux_w;
  assign unused_mux_w = mux_w;
  assign w_mismatch   = 1'b0;
`endif

  scan_settle_cnt u_settle_cnt (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (cnt_load),
    .load_val_i (SettleLoad),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StSettle;
          idx_d    = '0;
          err_d    = 1'b0;
          cnt_load = 1'b1;
        end
      end
      StSettle: begin
        cnt_dec = 1'b1;
        // Counter was loaded with SETTLE-1, so zero marks the last settle cycle.
        if (cnt_zero) begin
          state_d = StSample;
        end
      end
      StSample: begin
        data_d[idx_q] = mux_y;
        if (w_mismatch) begin
          err_d = 1'b1;
        end
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d    = idx_q + SCAN_IDX_W'(1);
          state_d  = StSettle;
          cnt_load = 1'b1;
        end
      end
      StDone: begin
        // start is deliberately ignored here, even on the handshake edge.
        if (ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode the registered state, so reset reaches them without a clock edge.
  assign {sel_a, sel_b, sel_c} = idx_q;
  assign g_n      = !((state_q == StSettle) || (state_q == StSample));
  assign data_out = data_q;
  assign valid    = (state_q == StDone);
  assign busy     = (state_q != StIdle);
  assign err      = err_q;

endmodule
